instruction_mem: RTL and testbench
==================================

Name: instruction_mem

Overview:
- Word-addressed instruction memory for the 16-bit pipelined MIPS core.
- Sits at the IF stage: the PC drives Address and the fetched instruction word appears on Content in the same cycle.
- A synchronous load port lets a bench or boot controller program the array.
- Asynchronous active-low reset clears the array, so a fetch after reset returns NOP (16'h0000).

Parameters:
- DEPTH, 256, number of 16-bit instruction words; power of two, 2..65536.
- WIDTH, 16, instruction word width in bits; fixed at 16 for this core.

Ports:
- Clk  input  1  system clock; all writes occur on its rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Address  input  16  word address of the instruction to fetch (PC value, word granularity).
- Content  output  16  instruction word at Address; combinational read.
- AddrFault  output  1  high when Address >= DEPTH; combinational.
- LoadEn  input  1  write strobe for the load port, sampled on rising Clk.
- LoadAddr  input  16  word address to write.
- LoadData  input  16  word to write.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Storage: DEPTH x 16-bit register array.
- Reset:
  - When Reset_n falls, every array word clears to 16'h0000 immediately, with no clock needed.
  - The array stays cleared while Reset_n is low.
  - LoadEn is ignored during reset.
- Read:
  - Purely combinational; zero-cycle latency.
  - Content = mem[Address] when Address < DEPTH.
  - Content = 16'h0000 (NOP) when Address >= DEPTH, and AddrFault = 1.
  - AddrFault = 0 otherwise.
  - Content and AddrFault are valid during reset: Content reads 0 for every address, and AddrFault follows Address.
  - Content never goes X, including for out-of-range addresses.
- Write:
  - On rising Clk with Reset_n high, LoadEn = 1 and LoadAddr < DEPTH: mem[LoadAddr] <= LoadData.
  - LoadAddr >= DEPTH: write silently dropped; no other word changes.
  - LoadEn = 0: no change.
- Read-during-write, same address: Content shows the old word before the edge and the new word immediately after it. There is no bypass of LoadData onto Content.
- Reset asserted in the same instant as a write edge: reset wins and the word stays 0.
- Address is not registered. Upper address bits above log2(DEPTH) participate only in the fault/range check.
- No internal state other than the array.

Test Plan:
1. Reset_n = 0 for 100 ns, then 1. Sweep Address 0, 1, 2, 19 at 10 ns intervals -> Content = 16'h0000 at each, AddrFault = 0.
2. After reset, load mem[1] = 16'h2041, mem[2] = 16'h8C22, mem[19] = 16'hFFFF via LoadEn pulses. Then Address = 1, 2, 19 -> Content = 16'h2041, 16'h8C22, 16'hFFFF, with no clock needed between address changes.
3. Address = 19 while loading mem[19] = 16'h1234 (previously 16'hFFFF):
   - before the edge, Content = 16'hFFFF;
   - after the rising edge, Content = 16'h1234.
4. Address = 256 (DEPTH = 256) -> Content = 16'h0000, AddrFault = 1. Then LoadEn with LoadAddr = 300, LoadData = 16'hABCD -> Address = 44 (300 mod 256) still reads its prior value, with no aliasing.
5. After programming, drop Reset_n asynchronously mid-cycle -> Content for Address = 2 goes to 16'h0000 without a clock edge. A LoadEn pulse while Reset_n = 0 leaves the word at 0.
6. Write mem[0] = 16'h5555 with LoadEn = 0 -> Address = 0 still reads 16'h0000.

Source files
------------

// File: rtl/instruction_mem_if.sv
// Fetch and load signals of the instruction memory.
// The fetch side is a combinational lookup, and the load side is a strobe with no backpressure.
interface instruction_mem_if;
    logic [15:0] Address;
    logic [15:0] Content;
    logic        AddrFault;
    logic        LoadEn;
    logic [15:0] LoadAddr;
    logic [15:0] LoadData;

    // LoadEn is a valid-only strobe. The memory is always ready, so every word strobed
    // on a rising clock is either written or dropped (when out of range).
    modport master (
        output Address,
        output LoadEn,
        output LoadAddr,
        output LoadData,
        input  Content,
        input  AddrFault
    );

    modport slave (
        input  Address,
        input  LoadEn,
        input  LoadAddr,
        input  LoadData,
        output Content,
        output AddrFault
    );
endinterface

// File: rtl/instruction_mem.sv
// Word-addressed instruction memory for the IF stage.
// It has a combinational fetch, a synchronous load port and an asynchronous clear.
module instruction_mem #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    instruction_mem_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_in_range;
    logic             ld_in_range;

    // The full 16-bit address takes part in the range check, so upper bits never alias.
    assign rd_in_range = (32'(bus.Address) < DEPTH);
    assign ld_in_range = (32'(bus.LoadAddr) < DEPTH);

    assign bus.AddrFault = ~rd_in_range;
    assign bus.Content   = rd_in_range ? mem[bus.Address[AW-1:0]] : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.LoadEn && ld_in_range) begin
            mem[bus.LoadAddr[AW-1:0]] <= bus.LoadData;
        end
    end
endmodule

// File: tb/tb_instruction_mem.sv
// Self-checking bench for instruction_mem. It runs directed scenarios and then random
// loads and fetches against an array model.
module tb_instruction_mem;
    localparam int DEPTH = 256;

    logic Clk;
    logic Reset_n;
    instruction_mem_if bus ();

    instruction_mem #(.DEPTH(DEPTH), .WIDTH(16)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ref_mem [DEPTH];
    logic [15:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_content(input int addr);
        return (addr < DEPTH) ? ref_mem[addr] : 16'h0000;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    endtask

    // Driver tasks
    task automatic load_word(input int addr, input logic [15:0] data, input logic en);
        @(negedge Clk);
        bus.LoadEn   = en;
        bus.LoadAddr = 16'(addr);
        bus.LoadData = data;
        @(posedge Clk);
        if (en && Reset_n && addr < DEPTH) ref_mem[addr] = data;
        @(negedge Clk);
        bus.LoadEn = 1'b0;
    endtask

    task automatic fetch_check(input string tag, input int addr);
        logic [15:0] exp;
        bus.Address = 16'(addr);
        exp_q.push_back(model_content(addr));
        #1;
        exp = exp_q.pop_front();
        check_eq({tag, "_content"}, bus.Content, exp);
        check_eq({tag, "_fault"}, {15'd0, bus.AddrFault}, {15'd0, addr >= DEPTH});
    endtask

    initial begin
        int a;
        int sweep [4];
        sweep = '{0, 1, 2, 19};
        bus.Address  = 16'd0;
        bus.LoadEn   = 1'b0;
        bus.LoadAddr = 16'd0;
        bus.LoadData = 16'd0;
        Reset_n      = 1'b0;
        model_clear();

        // Content and AddrFault are valid while reset is held.
        #20;
        fetch_check("in_reset_5", 5);
        fetch_check("in_reset_256", 256);
        // A load strobe during reset is ignored.
        load_word(7, 16'h1111, 1'b1);
        fetch_check("in_reset_load7", 7);
        #60;
        @(negedge Clk);
        Reset_n = 1'b1;

        // 1: sweep after reset, spaced 10 ns apart
        foreach (sweep[i]) begin
            fetch_check("post_reset", sweep[i]);
            #9;
        end

        // 2: program and fetch back without any clock between addresses
        load_word(1, 16'h2041, 1'b1);
        load_word(2, 16'h8C22, 1'b1);
        load_word(19, 16'hFFFF, 1'b1);
        fetch_check("prog_1", 1);
        fetch_check("prog_2", 2);
        fetch_check("prog_19", 19);

        // 3: read-during-write, with no bypass of LoadData
        @(negedge Clk);
        bus.Address  = 16'd19;
        bus.LoadEn   = 1'b1;
        bus.LoadAddr = 16'd19;
        bus.LoadData = 16'h1234;
        #1;
        check_eq("rdw_before", bus.Content, 16'hFFFF);
        @(posedge Clk);
        #1;
        check_eq("rdw_after", bus.Content, 16'h1234);
        ref_mem[19] = 16'h1234;
        @(negedge Clk);
        bus.LoadEn = 1'b0;

        // 4: out-of-range fetch and a dropped out-of-range load
        fetch_check("oor_256", 256);
        fetch_check("oor_ffff", 65535);
        load_word(44, 16'h0A0A, 1'b1);
        load_word(300, 16'hABCD, 1'b1);
        fetch_check("no_alias_44", 44);
        fetch_check("no_alias_19", 19);

        // 5: asynchronous clear in the middle of a cycle
        @(posedge Clk);
        #2;
        bus.Address = 16'd2;
        #1;
        check_eq("pre_async_2", bus.Content, 16'h8C22);
        Reset_n = 1'b0;
        model_clear();
        #1;
        check_eq("async_clear_2", bus.Content, 16'h0000);
        load_word(2, 16'h7777, 1'b1);
        fetch_check("reset_load_2", 2);
        @(negedge Clk);
        Reset_n = 1'b1;
        fetch_check("after_release_19", 19);

        // 6: data presented with LoadEn low is not written
        load_word(0, 16'h5555, 1'b0);
        fetch_check("en_low_0", 0);

        // Random loads and fetches against the model
        for (int n = 0; n < 300; n++) begin
            a = $urandom_range(0, 399);
            load_word(a, 16'($urandom), ($urandom_range(0, 3) != 0));
            fetch_check("rand_fetch", $urandom_range(0, 299));
            fetch_check("rand_same", a);
        end

        // Final sweep of the whole array and a few upper addresses
        for (int i = 0; i < DEPTH + 4; i++) begin
            fetch_check("sweep", i);
        end
        fetch_check("sweep_top", 65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
